// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// default sizing and the constant returned on errors and writes.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int DEFAULT_MEM_WORDS = 1024;
  localparam int DEFAULT_READ_LAT  = 2;

  localparam logic [31:0] ERR_DATA = 32'h0;

  // Word-index width for a given depth, never narrower than one bit.
  function automatic int addr_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // A byte address is usable only when word aligned and inside the array.
  function automatic logic addr_legal(input logic [15:0] addr, input int words);
    return (addr[1:0] == 2'b00) && ({18'd0, addr[15:2]} < 32'(words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents have no reset so they survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int AW        = addr_bits(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Store the word on the clock edge when the responder commits a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one request at a time,
// holds the pipeline while it is serviced and returns a one-cycle response
// READ_LAT cycles after acceptance.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int READ_LAT  = DEFAULT_READ_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int         AW       = addr_bits(MEM_WORDS);
  localparam logic [2:0] CNT_LOAD = (READ_LAT >= 2) ? 3'(READ_LAT - 2) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic          accept;
  logic          enter_resp;
  logic          eff_we;
  logic [15:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic          addr_ok;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [31:0]   arr_rdata;

  assign accept = req_valid && (state_q == ST_IDLE);

  // With READ_LAT=1 the access completes on the acceptance edge itself, so
  // in IDLE the live request is used; otherwise the latched copy is used.
  always_comb begin
    eff_we    = we_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end
  end

  assign addr_ok  = addr_legal(eff_addr, MEM_WORDS);
  assign arr_addr = eff_addr[AW+1:2];

  // Next-state logic, latency counter and request capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (READ_LAT == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response contents are formed on the edge entering RESP; a reset on that
  // same edge must keep a pending write out of the array.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_rdata_d = ERR_DATA;
    rsp_err_d   = 1'b0;
    arr_we      = enter_resp && eff_we && addr_ok && !reset;
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !addr_ok;
      if (!eff_we && addr_ok) begin
        rsp_rdata_d = arr_rdata;
      end
    end
  end

  // State, counter, request latch and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (eff_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = req_valid && (state_q != ST_RESP);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance with READ_LAT=2 and one with
// READ_LAT=1, directed requests with expected responses queued at issue
// and a negedge monitor that pops and compares each response.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        stall     [2];

  int   vectors;
  int   miscompares;
  int   cyc;
  logic mon_en;
  exp_t sb0[$];
  exp_t sb1[$];

  dmem_responder #(.MEM_WORDS(1024), .READ_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.MEM_WORDS(1024), .READ_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .stall(stall[1])
  );

  // Free-running clock and cycle counter used to time responses.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard on every response strobe and checks idle outputs stay zero.
  task automatic checkOutput(input int d);
    exp_t e;
    if (rsp_valid[d] === 1'b1) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        cmp($sformatf("unexpected_rsp_dut%0d", d), 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        cmp($sformatf("rsp_cycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
        cmp($sformatf("rsp_rdata_dut%0d", d), rsp_rdata[d], e.rdata);
        cmp($sformatf("rsp_err_dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
      end
    end else begin
      cmp($sformatf("idle_rsp_zero_dut%0d", d), rsp_rdata[d] | {31'd0, rsp_err[d]}, 32'd0);
    end
    if (d == 1) begin
      cmp("lat1_no_access", {31'd0, dut_lat1.state_q == ST_ACCESS}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput(0);
      checkOutput(1);
    end
  end

  // Issues one request, queues its expected response and checks stall/ready
  // through to the RESP cycle; drop=0 leaves req_valid high through RESP.
  task automatic applyStimulus(input int d, input logic we, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic drop);
    exp_t e;
    int   lat;
    lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    e.cyc   = cyc + lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    #1;
    cmp("ready_at_T", {31'd0, req_ready[d]}, 32'd1);
    cmp("stall_at_T", {31'd0, stall[d]}, 32'd1);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      #1;
      cmp("stall_in_access", {31'd0, stall[d]}, 32'd1);
      cmp("ready_in_access", {31'd0, req_ready[d]}, 32'd0);
    end
    @(negedge clk);
    #1;
    cmp("stall_in_resp", {31'd0, stall[d]}, 32'd0);
    cmp("ready_in_resp", {31'd0, req_ready[d]}, 32'd0);
    if (drop) req_valid[d] = 1'b0;
  endtask

  // Starts a write on the READ_LAT=2 instance and resets it mid-access.
  task automatic applyAbort(input logic [15:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = addr;
    req_wdata[0] = wdata;
    #1;
    cmp("abort_ready_at_T", {31'd0, req_ready[0]}, 32'd1);
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0]     = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    cmp("abort_idle_at_T2", {31'd0, req_ready[0]}, 32'd1);
    cmp("abort_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
  endtask

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 16'd0;
      req_wdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp("reset_ready", {31'd0, req_ready[d]}, 32'd1);
      cmp("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      cmp("reset_rsp_data", rsp_rdata[d] | {31'd0, rsp_err[d]}, 32'd0);
      req_valid[d] = 1'b1;
      #1;
      cmp("reset_stall_follows_high", {31'd0, stall[d]}, 32'd1);
      req_valid[d] = 1'b0;
      #1;
      cmp("reset_stall_follows_low", {31'd0, stall[d]}, 32'd0);
    end
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    mon_en   = 1'b1;

    // READ_LAT=2: write then read back, misaligned write, out-of-range read, top word
    applyStimulus(0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 16'h0012, 32'h12345678, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 16'h0FFC, 32'hA5A55A5A, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 16'h0FFC, 32'h0, 32'hA5A55A5A, 1'b0, 1'b1);

    // Reset during ACCESS must drop the pending write
    applyStimulus(0, 1'b1, 16'h0020, 32'h11112222, 32'h0, 1'b0, 1'b1);
    applyAbort(16'h0020, 32'hCAFEF00D);
    applyStimulus(0, 1'b0, 16'h0020, 32'h0, 32'h11112222, 1'b0, 1'b1);

    // req_valid held through RESP: back-to-back acceptances, one pulse each
    applyStimulus(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 16'h0020, 32'h0, 32'h11112222, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 16'h0024, 32'h00000077, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 16'h0024, 32'h0, 32'h00000077, 1'b0, 1'b1);

    // READ_LAT=1: response the cycle after acceptance, ACCESS never used
    applyStimulus(1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 16'h0012, 32'h12345678, 32'h0, 1'b1, 1'b1);
    applyStimulus(1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    #1;
    cmp("sb0_drained", 32'(sb0.size()), 32'd0);
    cmp("sb1_drained", 32'(sb1.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
